alu_issue_ctrl: RTL

// Issuing side of the ALU operand/opcode interface. Accepts one 32-bit MIPS-style instruction per handshake.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_issue_ctrl_regfile.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand interface: operateType codes, instruction
// opcode/funct values and the issue controller's FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_LUI = 3'b110;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file: two combinational operand read ports, one debug read port and
// one synchronous write port. Register 0 is hardwired to zero.
module alu_issue_ctrl_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [REG_N];

  // NOTE: the whole array is cleared on reset because the architecture promises
  // every register reads 0 afterwards; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts one instruction per
// handshake, reads operands, drives the ALU and writes the result back.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_num1,
  output logic [DATA_W-1:0] alu_num2,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              zero_out,
  output logic              illegal,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state, state_next;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] rdata1, rdata2;

  logic              dec_legal;
  logic              dec_lui;
  logic [2:0]        dec_op;
  logic [ADDR_W-1:0] dec_dest;

  // Decode is purely a function of the latched instruction, so it stays valid
  // from DECODE through WB without extra pipeline registers.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_legal = 1'b0;
    dec_lui   = 1'b0;
    dec_op    = ALU_ADD;
    dec_dest  = instr_q[15:11];
    unique case (instr_q[31:26])
      OP_RTYPE: begin
        unique case (instr_q[5:0])
          FN_ADD:  begin dec_legal = 1'b1; dec_op = ALU_ADD; end
          FN_SUB:  begin dec_legal = 1'b1; dec_op = ALU_SUB; end
          FN_AND:  begin dec_legal = 1'b1; dec_op = ALU_AND; end
          FN_OR:   begin dec_legal = 1'b1; dec_op = ALU_OR;  end
          FN_XOR:  begin dec_legal = 1'b1; dec_op = ALU_XOR; end
          default: ;
        endcase
      end
      OP_LUI: begin
        dec_legal = 1'b1;
        dec_lui   = 1'b1;
        dec_op    = ALU_LUI;
        dec_dest  = instr_q[20:16];
      end
      default: ;
    endcase
  end

  alu_issue_ctrl_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1   (instr_q[25:21]),
    .rdata1   (rdata1),
    .raddr2   (instr_q[20:16]),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       ((state == S_WB) && dec_legal),
    .waddr    (dec_dest),
    .wdata    (res_q)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (instr_valid) state_next = S_DECODE;
      S_DECODE: state_next = dec_legal ? S_EXEC : S_WB;
      S_EXEC:   state_next = S_WB;
      S_WB:     state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign instr_ready = (state == S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      res_q    <= '0;
      alu_num1 <= '0;
      alu_num2 <= '0;
      alu_op   <= ALU_ADD;
      done     <= 1'b0;
      zero_out <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      unique case (state)
        S_IDLE: if (instr_valid) instr_q <= instr_in;
        S_DECODE: begin
          // Illegal instructions leave the ALU inputs untouched.
          if (dec_legal) begin
            alu_num1 <= dec_lui ? '0 : rdata1;
            alu_num2 <= dec_lui ? {{(DATA_W-16){1'b0}}, instr_q[15:0]} : rdata2;
            alu_op   <= dec_op;
          end
        end
        S_EXEC: res_q <= alu_result;
        S_WB: begin
          done    <= 1'b1;
          illegal <= ~dec_legal;
          if (dec_legal) zero_out <= (res_q == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
